// File: rtl/mac_scan_driver_pkg.sv
// Shared definitions for the MAC pad-ring scan driver.
package mac_scan_driver_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    CAPTURE   = 3'd2,
    SHIFT_OUT = 3'd3,
    DONE      = 3'd4
  } state_t;

endpackage

// File: rtl/mac_scan_shreg.sv
// Parallel-load, shift-left register; MSB is the serial output, LSB takes serial input.
module mac_scan_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], serial_in};
    end
  end

endmodule

// File: rtl/mac_scan_driver.sv
// Tester-side scan controller: shift a pattern into the chip chain, run capture
// cycles, shift the response back out and compare it under a mask.
module mac_scan_driver
  import mac_scan_driver_pkg::*;
#(
  parameter int CHAIN_LEN      = 32,
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expect_val,
  input  logic [CHAIN_LEN-1:0] mask,
  output logic                 scanin,
  output logic                 scan_en,
  input  logic                 scanout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] captured
);

  localparam int CNT_MAX = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CHAIN_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAPTURE_CYCLES - 1);

  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic                 scan_en_d, busy_d, done_d;
  logic                 res_upd, pat_load, pat_shift, cap_shift;
  logic [CHAIN_LEN-1:0] pat_load_val, pat_q, cap_q, exp_q, mask_q;
  logic                 running;
  logic                 pat_unused;

  assign running = (state == SHIFT_IN) || (state == CAPTURE) || (state == SHIFT_OUT);

  // scanin is the pattern register's MSB; once the pattern has fully shifted
  // out the register holds zeros, so scanin stays 0 in CAPTURE/SHIFT_OUT.
  assign scanin     = pat_q[CHAIN_LEN-1];
  assign pat_unused = ^pat_q[CHAIN_LEN-2:0];

  mac_scan_shreg #(.WIDTH(CHAIN_LEN)) u_pat_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (pat_load),
    .load_val  (pat_load_val),
    .shift     (pat_shift),
    .serial_in (1'b0),
    .q         (pat_q)
  );

  mac_scan_shreg #(.WIDTH(CHAIN_LEN)) u_cap_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_val  ('0),
    .shift     (cap_shift),
    .serial_in (scanout),
    .q         (cap_q)
  );

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      exp_q  <= expect_val;
      mask_q <= mask;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    scan_en_d    = 1'b0;
    busy_d       = busy;
    done_d       = 1'b0;
    res_upd      = 1'b0;
    pat_load     = 1'b0;
    pat_load_val = pattern;
    pat_shift    = 1'b0;
    cap_shift    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT_IN;
          cnt_d     = '0;
          pat_load  = 1'b1;
          scan_en_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      SHIFT_IN: begin
        pat_shift = 1'b1;
        if (cnt == CHAIN_LAST) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d     = cnt + CNT_W'(1);
          scan_en_d = 1'b1;
        end
      end
      CAPTURE: begin
        if (cnt == CAP_LAST) begin
          state_d   = SHIFT_OUT;
          cnt_d     = '0;
          scan_en_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      // The chip's scanout is sampled on every edge that sees scan_en high here.
      SHIFT_OUT: begin
        cap_shift = 1'b1;
        if (cnt == CHAIN_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d     = cnt + CNT_W'(1);
          scan_en_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        res_upd = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (abort && running) begin
      state_d      = IDLE;
      cnt_d        = '0;
      scan_en_d    = 1'b0;
      busy_d       = 1'b0;
      pat_load     = 1'b1;
      pat_load_val = '0;
      pat_shift    = 1'b0;
      cap_shift    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      scan_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      captured <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      scan_en <= scan_en_d;
      busy    <= busy_d;
      done    <= done_d;
      if (res_upd) begin
        captured <= cap_q;
        pass     <= (((cap_q ^ exp_q) & mask_q) == '0);
      end
    end
  end

endmodule

// File: tb/tb_mac_scan_driver.sv
// Bench for mac_scan_driver: 8-flop chip chain model that inverts its state on capture.
module tb_mac_scan_driver;

  localparam int L = 8;

  logic         clk = 1'b0;
  logic         rst, start, abort;
  logic [L-1:0] pattern, expect_val, mask;
  logic         scanin, scan_en, scanout, busy, done, pass;
  logic [L-1:0] captured;

  logic         start3, abort3;
  logic [L-1:0] pattern3, expect3, mask3;
  logic         scanin3, scan_en3, scanout3, busy3, done3, pass3;
  logic [L-1:0] captured3;

  logic [L-1:0] chain, chain3;

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  typedef struct {
    logic [L-1:0] cap;
    logic         ps;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mac_scan_driver #(.CHAIN_LEN(L), .CAPTURE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pattern(pattern), .expect_val(expect_val), .mask(mask),
    .scanin(scanin), .scan_en(scan_en), .scanout(scanout),
    .busy(busy), .done(done), .pass(pass), .captured(captured)
  );

  mac_scan_driver #(.CHAIN_LEN(L), .CAPTURE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3),
    .pattern(pattern3), .expect_val(expect3), .mask(mask3),
    .scanin(scanin3), .scan_en(scan_en3), .scanout(scanout3),
    .busy(busy3), .done(done3), .pass(pass3), .captured(captured3)
  );

  // Chip chain models: shift toward scanout when scan_en, otherwise capture ~state.
  always_ff @(posedge clk) begin
    if (scan_en) chain <= {chain[L-2:0], scanin};
    else         chain <= ~chain;
    if (scan_en3) chain3 <= {chain3[L-2:0], scanin3};
    else          chain3 <= ~chain3;
  end
  assign scanout  = chain[L-1];
  assign scanout3 = chain3[L-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : scoreboard
    exp_t e;
    if (rst && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_captured", 32'(captured), 32'(e.cap));
        check("sb_pass", 32'(pass), 32'(e.ps));
      end
    end
  end

  task automatic run_test(input string tag, input logic [L-1:0] pat, ex, mk, input logic ab);
    exp_t        e;
    int          lat;
    logic [L-1:0] sin;
    logic [17:0] se, se_exp;
    @(negedge clk);
    pattern = pat; expect_val = ex; mask = mk; start = 1'b1; abort = ab;
    e.cap = ~pat;
    e.ps  = (((~pat) ^ ex) & mk) == '0;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    lat = -1; sin = '0; se = '0;
    for (int p = 0; p < 18; p++) se_exp[p] = (p < L) || (p >= L + 1 && p < 2 * L + 1);
    for (int p = 0; p < 100; p++) begin
      @(negedge clk);
      if (p < L) sin[L-1-p] = scanin;
      if (p < 18) se[p] = scan_en;
      if (done) begin
        lat = p;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd18);
    check({tag, "_scanin"}, 32'(sin), 32'(pat));
    check({tag, "_scan_en"}, 32'(se), 32'(se_exp));
  endtask

  initial begin
    int lat, dc, low;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = '0; expect_val = '0; mask = '0;
    start3 = 1'b0; abort3 = 1'b0;
    pattern3 = 8'hA5; expect3 = 8'h5A; mask3 = 8'hFF;
    repeat (2) @(negedge clk);
    check("rst_scanin", 32'(scanin), 32'd0);
    check("rst_scan_en", 32'(scan_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_captured", 32'(captured), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_test("t1", 8'hA5, 8'h5A, 8'hFF, 1'b0);
    run_test("t2a", 8'hA5, 8'h5B, 8'hFF, 1'b0);
    run_test("t2b", 8'hA5, 8'h5B, 8'hFE, 1'b1);

    // abort on the 3rd SHIFT_OUT cycle
    @(negedge clk);
    pattern = 8'h3C; expect_val = 8'h00; mask = 8'hFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2 * L - 4) @(negedge clk);
    check("t3_busy_before", 32'(busy), 32'd1);
    check("t3_scan_en_before", 32'(scan_en), 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("t3_scan_en", 32'(scan_en), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_scanin", 32'(scanin), 32'd0);
    dc = done_cnt;
    repeat (25) @(negedge clk);
    check("t3_no_done", 32'(done_cnt), 32'(dc));
    check("t3_captured", 32'(captured), 32'h5A);
    check("t3_pass", 32'(pass), 32'd1);

    // start while busy, pattern changed after the start edge
    @(negedge clk);
    pattern = 8'h0F; expect_val = 8'hF0; mask = 8'hFF; start = 1'b1;
    sb.push_back('{cap: 8'hF0, ps: 1'b1});
    dc = done_cnt;
    @(posedge clk);
    #1 start = 1'b0; pattern = 8'hFF; expect_val = 8'h00;
    lat = -1;
    for (int p = 0; p < 100; p++) begin
      @(negedge clk);
      if (p == 3) start = 1'b1;
      if (p == 4) start = 1'b0;
      if (done) begin
        lat = p;
        break;
      end
    end
    check("t4_latency", 32'(lat), 32'd18);
    repeat (25) @(negedge clk);
    check("t4_single_done", 32'(done_cnt), 32'(dc + 1));

    // asynchronous reset in the middle of SHIFT_IN
    @(negedge clk);
    pattern = 8'h33; expect_val = 8'h00; mask = 8'hFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t5_scanin", 32'(scanin), 32'd0);
    check("t5_scan_en", 32'(scan_en), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_pass", 32'(pass), 32'd0);
    check("t5_captured", 32'(captured), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_test("t5_after", 8'hFF, 8'h00, 8'hFF, 1'b0);

    // CAPTURE_CYCLES=3 instance
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    lat = -1; low = 0;
    for (int p = 0; p < 100; p++) begin
      @(negedge clk);
      if (p < 2 * L + 3 && !scan_en3) low++;
      if (done3) begin
        lat = p;
        break;
      end
    end
    check("t6_latency", 32'(lat), 32'd20);
    check("t6_scan_en_low", 32'(low), 32'd3);
    check("t6_captured", 32'(captured3), 32'h5A);
    check("t6_pass", 32'(pass3), 32'd1);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
